// File: rtl/keycode_event_queue.sv
// Turns the level keycode from the USB keyboard PIO into press/release events in a FWFT FIFO.
// Optional auto-repeat of a held key is built when KEYCODE_AUTOREPEAT_EN is defined.
module keycode_event_queue #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             keycode_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             evt_code,
  output logic                   evt_press,
  output logic                   evt_repeat,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic [7:0]             held_key
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1 || REPEAT_DELAY > 2**25) begin : g_bad_params
    $error("keycode_event_queue: illegal parameter values");
  end

  typedef struct packed {
    logic [7:0] code;
    logic       press;
`ifdef KEYCODE_AUTOREPEAT_EN
    logic       rpt;
`endif
  } evt_t;

  typedef enum logic {IDLE, PRS} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    nxt_q, nxt_d;
  evt_t          mem_q [DEPTH];
  evt_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, full, push_ok, drop;
  evt_t          push_evt;
  evt_t          head;

`ifdef KEYCODE_AUTOREPEAT_EN
  localparam logic [24:0] DLY_M1  = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] RATE_M1 = 25'(REPEAT_RATE - 1);

  // Phase 0 waits out the initial delay, phase 1 paces the following repeats.
  logic [24:0] rcnt_q, rcnt_d;
  logic        rphase_q, rphase_d;
  logic        rpt_run, rpt_fire;

  assign rpt_run  = (state_q == IDLE) && (keycode_in == cur_q) && (cur_q != 8'h00);
  assign rpt_fire = rpt_run && (rcnt_q == (rphase_q ? RATE_M1 : DLY_M1));

  always_comb begin
    rcnt_d   = '0;
    rphase_d = 1'b0;
    if (rpt_fire) begin
      rphase_d = 1'b1;
    end else if (rpt_run) begin
      rcnt_d   = rcnt_q + 25'd1;
      rphase_d = rphase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    push     = 1'b0;
    push_evt = '0;
    case (state_q)
      IDLE: begin
        if (keycode_in != cur_q) begin
          nxt_d = keycode_in;
          push  = 1'b1;
          if (cur_q != 8'h00) begin
            push_evt.code = cur_q;
            if (keycode_in != 8'h00) state_d = PRS;
            else                     cur_d   = 8'h00;
          end else begin
            push_evt.code  = keycode_in;
            push_evt.press = 1'b1;
            cur_d          = keycode_in;
          end
`ifdef KEYCODE_AUTOREPEAT_EN
        end else if (rpt_fire) begin
          push           = 1'b1;
          push_evt.code  = cur_q;
          push_evt.press = 1'b1;
          push_evt.rpt   = 1'b1;
`endif
        end
      end
      PRS: begin
        // Second half of a key switch; the input is deliberately not sampled here.
        push           = 1'b1;
        push_evt.code  = nxt_q;
        push_evt.press = 1'b1;
        cur_d          = nxt_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (count_q != '0) && evt_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_evt;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    ovf_d   = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cur_q    <= 8'h00;
      nxt_q    <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign evt_valid = (count_q != '0);
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_press = evt_valid & head.press;
`ifdef KEYCODE_AUTOREPEAT_EN
  assign evt_repeat = evt_valid & head.rpt;
`else
  assign evt_repeat = 1'b0;
`endif
  assign evt_count = count_q;
  assign overflow  = ovf_q;
  assign held_key  = cur_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Bench for keycode_event_queue: queue-based event model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_keycode_event_queue;
  localparam int DEPTH = 8;
  localparam int RD    = 10;
  localparam int RR    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode_in = 8'h00;
  logic       evt_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       evt_valid, evt_press, evt_repeat, overflow;
  logic [7:0] evt_code, held_key;
  logic [3:0] evt_count;

  keycode_event_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset_n(reset_n), .keycode_in(keycode_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_press(evt_press), .evt_repeat(evt_repeat), .evt_count(evt_count),
    .overflow(overflow), .clear_overflow(clear_overflow), .held_key(held_key)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] code;
    logic       press;
    logic       rep;
  } ev_t;

  // Reference: a plain queue of events, the tracked key, a pending second-half press and a held-cycle count.
  ev_t        mq[$];
  logic [7:0] m_cur, m_pend;
  bit         m_pend_vld, m_ovf, m_have, m_pop;
  int         m_held;
  ev_t        m_ev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_cur = 8'h00; m_pend = 8'h00; m_pend_vld = 0; m_ovf = 0; m_held = 0;
    end else begin
      m_have = 0;
      m_ev   = '0;
      m_pop  = (mq.size() != 0) && evt_ready;
      if (m_pend_vld) begin
        m_ev = '{code: m_pend, press: 1'b1, rep: 1'b0};
        m_have = 1; m_cur = m_pend; m_pend_vld = 0; m_held = 0;
      end else if (keycode_in != m_cur) begin
        m_have = 1; m_held = 0;
        if (m_cur != 8'h00) begin
          m_ev = '{code: m_cur, press: 1'b0, rep: 1'b0};
          if (keycode_in != 8'h00) begin m_pend_vld = 1; m_pend = keycode_in; end
          else m_cur = 8'h00;
        end else begin
          m_ev = '{code: keycode_in, press: 1'b1, rep: 1'b0};
          m_cur = keycode_in;
        end
      end else if (m_cur != 8'h00) begin
        m_held++;
`ifdef KEYCODE_AUTOREPEAT_EN
        if (m_held >= RD && (m_held - RD) % RR == 0) begin
          m_have = 1;
          m_ev = '{code: m_cur, press: 1'b1, rep: 1'b1};
        end
`endif
      end
      if (m_pop) void'(mq.pop_front());
      if (clear_overflow) m_ovf = 0;
      if (m_have) begin
        if (mq.size() < DEPTH) mq.push_back(m_ev);
        else m_ovf = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      chk("cyc_valid", evt_valid, mq.size() != 0);
      chk("cyc_count", evt_count, mq.size());
      chk("cyc_overflow", overflow, m_ovf);
      chk("cyc_held_key", held_key, m_cur);
      if (mq.size() != 0) begin
        chk("cyc_code", evt_code, mq[0].code);
        chk("cyc_press", evt_press, mq[0].press);
        chk("cyc_repeat", evt_repeat, mq[0].rep);
      end
    end
  end

  ev_t got[$];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int max_cyc);
    got.delete();
    evt_ready = 1'b1;
    for (int i = 0; i < max_cyc && evt_valid; i++) begin
      got.push_back('{code: evt_code, press: evt_press, rep: evt_repeat});
      @(negedge clk);
    end
    chk("drain_empty", evt_valid, 0);
    evt_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_code"}, evt_code, 0);
    chk({tag, "_press"}, evt_press, 0);
    chk({tag, "_repeat"}, evt_repeat, 0);
    chk({tag, "_count"}, evt_count, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_held"}, held_key, 0);
  endtask

  logic [7:0] keys [5];
  int vcnt;

  initial begin
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h1A; keys[4] = 8'h16;
    step(2);
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    step(1);

    // single press, consumer always ready
    evt_ready = 1'b1; keycode_in = 8'h1A;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        vcnt++;
        chk("t1_code", evt_code, 8'h1A);
        chk("t1_press", evt_press, 1);
      end
    end
    chk("t1_valid_cycles", vcnt, 1);
    chk("t1_held", held_key, 8'h1A);

    // direct key switch produces release then press
    evt_ready = 1'b0; keycode_in = 8'h07;
    step(3);
    chk("t2_count", evt_count, 2);
    chk("t2_held", held_key, 8'h07);
    drain(20);
    chk("t2_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("t2_e0_code", got[0].code, 8'h1A); chk("t2_e0_press", got[0].press, 0);
      chk("t2_e1_code", got[1].code, 8'h07); chk("t2_e1_press", got[1].press, 1);
    end
    keycode_in = 8'h00;
    step(3);
    drain(20);

    // overflow: ten single-push transitions into an eight-entry queue
    for (int t = 0; t < 10; t++) begin
      keycode_in = (t % 2 == 0) ? 8'h04 : 8'h00;
      step(3);
    end
    chk("t3_count", evt_count, 8);
    chk("t3_overflow", overflow, 1);
    drain(20);
    chk("t3_n", got.size(), 8);
    for (int i = 0; i < got.size(); i++) begin
      chk("t3_code", got[i].code, 8'h04);
      chk("t3_press", got[i].press, (i % 2 == 0) ? 1 : 0);
    end
    chk("t3_ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("t3_ovf_cleared", overflow, 0);

    // full queue, pop and push in the same cycle
    for (int t = 0; t < 8; t++) begin
      keycode_in = (t % 2 == 0) ? 8'h04 : 8'h00;
      step(3);
    end
    chk("t4_full_count", evt_count, 8);
    chk("t4_full_ovf", overflow, 0);
    evt_ready = 1'b1; keycode_in = 8'h04;
    step(1);
    evt_ready = 1'b0;
    chk("t4_count", evt_count, 8);
    chk("t4_ovf", overflow, 0);
    drain(40);
    chk("t4_n", got.size(), 8);
    if (got.size() == 8) begin
      chk("t4_last_code", got[7].code, 8'h04);
      chk("t4_last_press", got[7].press, 1);
      chk("t4_last_rep", got[7].rep, 0);
    end
    keycode_in = 8'h00;
    step(3);
    drain(20);

`ifdef KEYCODE_AUTOREPEAT_EN
    // auto-repeat: press, repeats at +10/+14/+18/+22/+26, then release
    keycode_in = 8'h16;
    step(10);
    chk("t5_before_rep", evt_count, 1);
    step(1);
    chk("t5_first_rep", evt_count, 2);
    step(17);
    keycode_in = 8'h00;
    step(10);
    chk("t5_count", evt_count, 7);
    drain(20);
    chk("t5_n", got.size(), 7);
    if (got.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        chk("t5_code", got[i].code, 8'h16);
        chk("t5_press", got[i].press, (i < 6) ? 1 : 0);
        chk("t5_rep", got[i].rep, (i >= 1 && i <= 5) ? 1 : 0);
      end
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      keycode_in     = keys[$urandom_range(0, 4)];
      evt_ready      = ($urandom_range(0, 2) != 0);
      clear_overflow = ($urandom_range(0, 9) == 0);
      step(($urandom_range(0, 7) == 0) ? $urandom_range(8, 24) : $urandom_range(1, 4));
    end
    clear_overflow = 1'b0;
    evt_ready = 1'b1;
    keycode_in = 8'h1A;
    step(20);

    // asynchronous reset in the middle of a key switch
    keycode_in = 8'h07;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    @(negedge clk);
    reset_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        vcnt++;
        chk("t6_code", evt_code, 8'h07);
        chk("t6_press", evt_press, 1);
      end
    end
    chk("t6_events", vcnt, 1);
    chk("t6_held", held_key, 8'h07);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
